// File: rtl/piece_collision_reader_pkg.sv
// Shared definitions for the collision reader and the sprite plotter ROMs:
// FSM encoding, default board size and the 4x4 mask bit ordering.
package piece_collision_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEFAULT_BOARD_W = 10;
   localparam int DEFAULT_BOARD_H = 20;

   // Row-major footprint: bit row*4+col, bit 0 is the top-left cell.
   localparam int MASK_ROW_STRIDE = 4;

   function automatic logic [3:0] mask_bit(input logic [1:0] row, input logic [1:0] col);
      return 4'(int'(row) * MASK_ROW_STRIDE + int'(col));
   endfunction

endpackage

// File: rtl/piece_collision_reader_if.sv
// Request/result handshake plus board RAM read port of the collision reader.
interface piece_collision_reader_if #(
   parameter int ADDR_W = 8
);
   logic              Start;
   logic signed [5:0] X;
   logic signed [5:0] Y;
   logic [15:0]       Mask;
   logic [ADDR_W-1:0] RdAddr;
   logic              RdEn;
   logic              RdData;
   logic              Busy;
   logic              Done;
   logic              Collide;

   modport slave (
      input  Start, X, Y, Mask, RdData,
      output RdAddr, RdEn, Busy, Done, Collide
   );

   modport master (
      output Start, X, Y, Mask, RdData,
      input  RdAddr, RdEn, Busy, Done, Collide
   );
endinterface

// File: rtl/piece_cell_addr.sv
// Maps a latched piece origin and cell index k to bounds flags and the
// board RAM address of that cell.
module piece_cell_addr #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int ADDR_W  = 8
) (
   input  logic signed [5:0]  org_x,
   input  logic signed [5:0]  org_y,
   input  logic [3:0]         k,
   output logic               in_bounds,
   output logic               above_board,
   output logic [ADDR_W-1:0]  addr
);

   localparam logic signed [6:0] WIDTH_S  = 7'(BOARD_W);
   localparam logic signed [6:0] HEIGHT_S = 7'(BOARD_H);

   logic signed [6:0] cell_x;
   logic signed [6:0] cell_y;
   logic              out_of_bounds;

   // Seven bits hold any 6-bit origin plus a 0..3 offset without wrapping.
   assign cell_x = {org_x[5], org_x} + {5'b00000, k[1:0]};
   assign cell_y = {org_y[5], org_y} + {5'b00000, k[3:2]};

   assign out_of_bounds = (cell_x < 7'sd0) || (cell_x >= WIDTH_S) || (cell_y >= HEIGHT_S);
   assign above_board   = !out_of_bounds && (cell_y < 7'sd0);
   assign in_bounds     = !out_of_bounds && !above_board;

   assign addr = in_bounds ? ADDR_W'(int'(cell_y) * BOARD_W + int'(cell_x)) : '0;

endmodule

// File: rtl/piece_collision_reader.sv
// Scans a 4x4 piece footprint from the board RAM and reports overlap or
// off-board placement. COLLIDE_EARLY_EXIT_EN stops at the first collision.
module piece_collision_reader
   import piece_collision_reader_pkg::*;
#(
   parameter int BOARD_W = DEFAULT_BOARD_W,
   parameter int BOARD_H = DEFAULT_BOARD_H,
   parameter int ADDR_W  = 8
) (
   input logic                      Clock,
   input logic                      Reset,
   piece_collision_reader_if.slave  bus
);

`ifdef COLLIDE_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   state_t            state;
   logic [3:0]        cell_k;
   logic signed [5:0] org_x;
   logic signed [5:0] org_y;
   logic [15:0]       mask_q;
   logic              hit;
   logic              rd_pending;
   logic              busy_q;
   logic              done_q;
   logic              collide_q;

   logic              cell_in_bounds;
   logic              cell_above;
   logic [ADDR_W-1:0] cell_addr;
   logic              cell_req;
   logic              cell_oob;
   logic              rd_en;
   logic              hit_now;
   logic              hit_next;

   piece_cell_addr #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H),
      .ADDR_W  (ADDR_W)
   ) u_cell_addr (
      .org_x       (org_x),
      .org_y       (org_y),
      .k           (cell_k),
      .in_bounds   (cell_in_bounds),
      .above_board (cell_above),
      .addr        (cell_addr)
   );

   assign cell_req = (state == ST_SCAN) && mask_q[mask_bit(cell_k[3:2], cell_k[1:0])];
   assign cell_oob = cell_req && !cell_in_bounds && !cell_above;
   assign rd_en    = cell_req && cell_in_bounds;

   // Read data only counts on the cycle after a real read was issued.
   assign hit_now  = cell_oob || (rd_pending && bus.RdData);
   assign hit_next = hit || hit_now;

   assign bus.RdEn    = rd_en;
   assign bus.RdAddr  = rd_en ? cell_addr : '0;
   assign bus.Busy    = busy_q;
   assign bus.Done    = done_q;
   assign bus.Collide = collide_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= ST_IDLE;
         cell_k     <= 4'd0;
         org_x      <= '0;
         org_y      <= '0;
         mask_q     <= '0;
         hit        <= 1'b0;
         rd_pending <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         collide_q  <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         rd_pending <= rd_en;
         case (state)
            ST_IDLE: begin
               if (bus.Start) begin
                  org_x     <= bus.X;
                  org_y     <= bus.Y;
                  mask_q    <= bus.Mask;
                  cell_k    <= 4'd0;
                  hit       <= 1'b0;
                  collide_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               hit    <= hit_next;
               cell_k <= cell_k + 4'd1;
               if (EARLY_EXIT && hit_now) begin
                  rd_pending <= 1'b0;
                  done_q     <= 1'b1;
                  collide_q  <= 1'b1;
                  state      <= ST_DONE;
               end else if (cell_k == 4'd15) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               hit       <= hit_next;
               collide_q <= hit_next;
               done_q    <= 1'b1;
               state     <= ST_DONE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
